// File: rtl/fifo_flex_pkg.sv
// ---------------------------------------------------------------------------
// fifo_flex_pkg
//
// Purpose : shared definitions for the fifo_flex FIFO and its storage array.
//           Provides the width helper used to size pointers and the occupancy
//           counter, the read-mode constants, and the parameter legality
//           check the top level evaluates at elaboration time.
//
// Contents:
//   clog2()          - number of bits needed to index 'value' distinct items
//   FIFO_STD         - registered read mode
//   FIFO_FWFT        - first-word-fall-through read mode
//   fifo_params_ok() - 1 when a parameter set describes a buildable FIFO
// ---------------------------------------------------------------------------
package fifo_flex_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Bits needed to represent the values 0..value-1. Never returns less
    // than 1, so a pointer into a two-entry array still gets a real bit.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // Legality of a parameter set. The thresholds must be reachable by the
    // occupancy counter, otherwise the almost flags would be stuck.
    function automatic bit fifo_params_ok(
        input int data_size,
        input int fifo_size,
        input int afull_level,
        input int aempty_level,
        input int mode
    );
        bit ok;
        ok = 1'b1;
        if (data_size < 1) ok = 1'b0;
        if (fifo_size < 2) ok = 1'b0;
        if (afull_level < 1 || afull_level > fifo_size) ok = 1'b0;
        if (aempty_level < 0 || aempty_level > fifo_size - 1) ok = 1'b0;
        if (mode != FIFO_STD && mode != FIFO_FWFT) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// ---------------------------------------------------------------------------
// fifo_flex_ram
//
// Purpose : storage array for fifo_flex. DATA_SIZE x FIFO_SIZE registers with
//           one synchronous write port and one asynchronous read port. There
//           is no reset: the FIFO tracks validity with its pointers and count,
//           so stale contents are never observed.
//
// Ports:
//   clock    in  1          write clock
//   wr_en    in  1          write strobe, samples wr_data at the rising edge
//   wr_addr  in  AW         write index, always < FIFO_SIZE
//   wr_data  in  DATA_SIZE  word to store
//   rd_addr  in  AW         read index, always < FIFO_SIZE
//   rd_data  out DATA_SIZE  word at rd_addr, combinational
// ---------------------------------------------------------------------------
module fifo_flex_ram
    import fifo_flex_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int FIFO_SIZE = 16,
    parameter int AW        = clog2(FIFO_SIZE)
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem [FIFO_SIZE];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The asynchronous read lets the top level either register the head
    // word (standard mode) or present it directly (FWFT mode).
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// ---------------------------------------------------------------------------
// fifo_flex
//
// Purpose : parametrised single-clock FIFO with any-depth wrap-around,
//           registered occupancy count and status flags, programmable
//           almost-full / almost-empty thresholds, sticky overflow and
//           underflow flags, synchronous flush, and a selectable standard or
//           first-word-fall-through read mode.
//
// Ports:
//   clock         in  1          single clock, rising edge
//   reset_n       in  1          asynchronous active-low reset
//   fifo_clear    in  1          synchronous flush, beats every other input
//   data_inen     in  1          write request
//   data_in       in  DATA_SIZE  write data
//   data_outen    in  1          read request (standard) / pop (FWFT)
//   data_out      out DATA_SIZE  read data
//   fifo_empty    out 1          count == 0
//   fifo_full     out 1          count == FIFO_SIZE
//   almost_empty  out 1          count <= AEMPTY_LEVEL
//   almost_full   out 1          count >= AFULL_LEVEL
//   fifo_count    out CW         words held
//   overflow      out 1          sticky, a write was rejected
//   underflow     out 1          sticky, a read was rejected
// ---------------------------------------------------------------------------
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int FIFO_SIZE    = 16,
    parameter int AFULL_LEVEL  = FIFO_SIZE - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = FIFO_STD,
    parameter int CW           = clog2(FIFO_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fifo_clear,
    input  logic                 data_inen,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 data_outen,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [CW-1:0]        fifo_count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PW = clog2(FIFO_SIZE);

    localparam logic [PW-1:0] PTR_LAST     = PW'(FIFO_SIZE - 1);
    localparam logic [CW-1:0] COUNT_FULL   = CW'(FIFO_SIZE);
    localparam logic [CW-1:0] COUNT_AFULL  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] COUNT_AEMPTY = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);

    // A bad parameter set stops elaboration instead of building a FIFO whose
    // flags can never toggle or whose pointers cannot address the array.
    if (!fifo_params_ok(DATA_SIZE, FIFO_SIZE, AFULL_LEVEL, AEMPTY_LEVEL, FWFT)) begin : g_bad_params
        $error("fifo_flex: illegal parameters (DATA_SIZE=%0d FIFO_SIZE=%0d AFULL_LEVEL=%0d AEMPTY_LEVEL=%0d FWFT=%0d)",
               DATA_SIZE, FIFO_SIZE, AFULL_LEVEL, AEMPTY_LEVEL, FWFT);
    end

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr_inc;
    logic [PW-1:0]        rd_ptr_inc;
    logic [CW-1:0]        count_next;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 ram_we;
    logic [DATA_SIZE-1:0] head_word;

    // Acceptance is decided from the registered flags only. A write into a
    // full FIFO is still accepted when a read frees a slot in the same edge;
    // a read of an empty FIFO is never accepted, even alongside a write.
    assign rd_ok  = data_outen && !fifo_empty;
    assign wr_ok  = data_inen && (!fifo_full || rd_ok);
    assign ram_we = wr_ok && !fifo_clear;

    // Explicit wrap so that depths which are not a power of two never step
    // into the unused upper pointer codes.
    assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

    // Occupancy after this edge. Every flag is derived from this value and
    // registered, so the flags describe the edge just taken and no input
    // reaches a flag combinationally.
    always_comb begin
        count_next = fifo_count;
        if (fifo_clear) begin
            count_next = '0;
        end else if (wr_ok && !rd_ok) begin
            count_next = fifo_count + COUNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_next = fifo_count - COUNT_ONE;
        end
    end

    // Read and write pointers; a flush returns both to the first slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (fifo_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    // Count and status flags, all loaded from the same next-count value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_count   <= '0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            fifo_count   <= count_next;
            fifo_empty   <= (count_next == '0);
            fifo_full    <= (count_next == COUNT_FULL);
            almost_empty <= (count_next <= COUNT_AEMPTY);
            almost_full  <= (count_next >= COUNT_AFULL);
        end
    end

    // Sticky error flags: set on the edge of a rejected request and held
    // until a flush or reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (fifo_clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (data_inen && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (data_outen && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_flex_ram #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_SIZE (FIFO_SIZE),
        .AW        (PW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // The head slot is always the oldest word, so it can be shown
        // directly. Gating with the registered empty flag keeps stale memory
        // contents off the output once the FIFO drains or is flushed.
        always_comb begin
            data_out = '0;
            if (!fifo_empty) begin
                data_out = head_word;
            end
        end
    end else begin : g_std
        // Standard mode: the head word is captured on the accepting edge and
        // held until the next accepted read, flush or reset.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_out <= '0;
            end else if (fifo_clear) begin
                data_out <= '0;
            end else if (rd_ok) begin
                data_out <= head_word;
            end
        end
    end

endmodule
